// File: rtl/mps_dmem_responder_pkg.sv
// ============================================================================
//  mps_dmem_responder_pkg
//  Types, constants and helpers shared by the data-memory responder slice.
//  Optional feature macro: DMEM_CYCLE_COUNTER_EN (cycle counter at top addr).
//  Revision: 1.0 - initial release
// ============================================================================
`include "config.inc.v"
`default_nettype none

package mps_dmem_responder_pkg;

    localparam int unsigned C_ADDR_W              = `DMEM_ADDR_WIDTH;
    localparam int unsigned C_DATA_W              = `DMEM_DATA_WIDTH;
    localparam int unsigned C_WAIT_W              = 3;
    localparam int unsigned C_STATE_W             = `DMEM_STATE_WIDTH;
    localparam int unsigned C_WAIT_STATES_DEFAULT = `DMEM_WAIT_STATES_DEFAULT;
    localparam int unsigned C_DEPTH_DEFAULT       = `DMEM_DEPTH_DEFAULT;

    typedef logic [C_ADDR_W-1:0] dmem_addr_t;
    typedef logic [C_DATA_W-1:0] dmem_data_t;
    typedef logic [C_WAIT_W-1:0] dmem_wait_t;

    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE = `DMEM_STATE_IDLE,
        ST_BUSY = `DMEM_STATE_BUSY,
        ST_DONE = `DMEM_STATE_DONE
    } dmem_state_t;

`ifdef DMEM_CYCLE_COUNTER_EN
    // The counter lives at the very last address of the address space.
    localparam dmem_addr_t C_CTR_ADDR = '1;
`endif

    // True when a word address maps onto an implemented storage word.
    function automatic logic addr_in_range(input dmem_addr_t addr,
                                           input int unsigned depth);
        return (32'(addr) < depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mps_dmem_if.sv
// ============================================================================
//  mps_dmem_if
//  CPU <-> data-memory request/response bundle. The CPU side is the master;
//  the responder is the slave.
//  Revision: 1.0 - initial release
// ============================================================================
`include "config.inc.v"
`default_nettype none

interface mps_dmem_if;
    import mps_dmem_responder_pkg::*;

    logic       dmem_req;
    dmem_addr_t dmem_addr;
    logic       dmem_wenable;
    dmem_data_t dmem_wvalue;
    dmem_data_t dmem_rvalue;
    logic       dmem_ready;

    modport master (
        output dmem_req,
        output dmem_addr,
        output dmem_wenable,
        output dmem_wvalue,
        input  dmem_rvalue,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_addr,
        input  dmem_wenable,
        input  dmem_wvalue,
        output dmem_rvalue,
        output dmem_ready
    );

endinterface

`default_nettype wire

// File: rtl/config.inc.v
// ============================================================================
//  config.inc.v
//  Shared width, default and state-encoding definitions for the data-memory
//  responder. Guarded so it can be included from every file of the slice.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MPS_DMEM_CONFIG_INC_V
`define MPS_DMEM_CONFIG_INC_V

`define DMEM_ADDR_WIDTH           8
`define DMEM_DATA_WIDTH           16

`define DMEM_WAIT_STATES_DEFAULT  1
`define DMEM_DEPTH_DEFAULT        (2**`DMEM_ADDR_WIDTH)

`define DMEM_STATE_WIDTH          2
`define DMEM_STATE_IDLE           2'd0
`define DMEM_STATE_BUSY           2'd1
`define DMEM_STATE_DONE           2'd2

`endif

`default_nettype wire

// File: rtl/mps_dmem_array.sv
// ============================================================================
//  mps_dmem_array
//  DEPTH-word storage with one synchronous write port and one registered read
//  port. Out-of-range writes are dropped, out-of-range reads load zero.
//  Storage contents are deliberately not reset.
//  Revision: 1.0 - initial release
// ============================================================================
`include "config.inc.v"
`default_nettype none

module mps_dmem_array
    import mps_dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = C_DEPTH_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic       i_wr_en,
    input  dmem_addr_t      i_wr_addr,
    input  dmem_data_t      i_wr_data,
    input  wire logic       i_rd_en,
    input  dmem_addr_t      i_rd_addr,
    output dmem_data_t      o_rd_data
);

    localparam int unsigned c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_data_t         r_mem [DEPTH];
    dmem_data_t         r_rd_data;

    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_rd_idx;
    logic               w_wr_ok;
    logic               w_rd_ok;

    assign w_wr_idx  = i_wr_addr[c_idx_w-1:0];
    assign w_rd_idx  = i_rd_addr[c_idx_w-1:0];
    assign w_wr_ok   = addr_in_range(i_wr_addr, DEPTH);
    assign w_rd_ok   = addr_in_range(i_rd_addr, DEPTH);
    assign o_rd_data = r_rd_data;

    // Storage write; no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (i_wr_en && w_wr_ok) begin
            r_mem[w_wr_idx] <= i_wr_data;
        end
    end

    // Registered read port; holds its value between read strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= w_rd_ok ? r_mem[w_rd_idx] : '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mps_dmem_responder.sv
// ============================================================================
//  mps_dmem_responder
//  Data-memory responder: accepts one CPU request in IDLE, waits WAIT_STATES
//  cycles in BUSY, completes in DONE with a one-cycle dmem_ready pulse.
//  Optional feature macro: DMEM_CYCLE_COUNTER_EN adds a free-running cycle
//  counter mapped at the top word address.
//  Revision: 1.0 - initial release
// ============================================================================
`include "config.inc.v"
`default_nettype none

module mps_dmem_responder
    import mps_dmem_responder_pkg::*;
#(
    parameter int unsigned WAIT_STATES = C_WAIT_STATES_DEFAULT,
    parameter int unsigned DEPTH       = C_DEPTH_DEFAULT
) (
    input  wire logic clock,
    input  wire logic reset,
    mps_dmem_if.slave bus
);

    // Value loaded into the wait counter when BUSY is entered.
    localparam dmem_wait_t c_wait_load =
        (WAIT_STATES > 0) ? dmem_wait_t'(WAIT_STATES - 1) : '0;

    dmem_state_t r_state;
    dmem_state_t w_state_nxt;
    logic        w_accept;
    logic        w_enter_done;

    dmem_wait_t  r_wait_cnt;
    dmem_addr_t  r_addr;
    logic        r_wen;
    dmem_data_t  r_wdata;

    dmem_addr_t  w_op_addr;
    logic        w_op_wen;
    dmem_data_t  w_op_wdata;

    logic        w_arr_wr_en;
    logic        w_arr_rd_en;
    dmem_data_t  w_arr_rd_data;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.dmem_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (WAIT_STATES > 0) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

    // Wait counter: loaded on accept, counts down while in BUSY.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= c_wait_load;
        end else if ((r_state == ST_BUSY) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    // Request capture so later bus activity cannot disturb the transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= bus.dmem_addr;
            r_wen   <= bus.dmem_wenable;
            r_wdata <= bus.dmem_wvalue;
        end
    end

    // With zero wait states the accept and completion share one edge, so the
    // live bus values are the operands; otherwise the captured copies are.
    assign w_op_addr  = (r_state == ST_IDLE) ? bus.dmem_addr     : r_addr;
    assign w_op_wen   = (r_state == ST_IDLE) ? bus.dmem_wenable  : r_wen;
    assign w_op_wdata = (r_state == ST_IDLE) ? bus.dmem_wvalue   : r_wdata;

    assign bus.dmem_ready = (r_state == ST_DONE);

`ifdef DMEM_CYCLE_COUNTER_EN
    dmem_data_t r_cycle_cnt;
    dmem_data_t r_ctr_snap;
    logic       r_rd_ctr_sel;
    logic       w_ctr_hit;

    assign w_ctr_hit   = (w_op_addr == C_CTR_ADDR);
    assign w_arr_wr_en = w_enter_done &&  w_op_wen && !w_ctr_hit;
    assign w_arr_rd_en = w_enter_done && !w_op_wen && !w_ctr_hit;

    // Free-running cycle counter; a write to its address clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (w_enter_done && w_op_wen && w_ctr_hit) begin
            r_cycle_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    // Counter read snapshot: the value the counter takes at the completing
    // edge, i.e. the number of edges since it was last cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ctr_sel <= 1'b0;
            r_ctr_snap   <= '0;
        end else if (w_enter_done && !w_op_wen) begin
            r_rd_ctr_sel <= w_ctr_hit;
            if (w_ctr_hit) begin
                r_ctr_snap <= r_cycle_cnt + 1'b1;
            end
        end
    end

    assign bus.dmem_rvalue = r_rd_ctr_sel ? r_ctr_snap : w_arr_rd_data;
`else
    assign w_arr_wr_en     = w_enter_done &&  w_op_wen;
    assign w_arr_rd_en     = w_enter_done && !w_op_wen;
    assign bus.dmem_rvalue = w_arr_rd_data;
`endif

    mps_dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk       (clock),
        .rst       (reset),
        .i_wr_en   (w_arr_wr_en),
        .i_wr_addr (w_op_addr),
        .i_wr_data (w_op_wdata),
        .i_rd_en   (w_arr_rd_en),
        .i_rd_addr (w_op_addr),
        .o_rd_data (w_arr_rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_mps_dmem_responder.sv
// ============================================================================
//  tb_mps_dmem_responder
//  Self-checking bench: three responders (2 wait states; 0 wait states;
//  2 wait states with 16 words) driven by directed and random transactions
//  and compared against a word-array model with formula-based timing.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mps_dmem_responder;
    import mps_dmem_responder_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic       t_req   [3];
    dmem_addr_t t_addr  [3];
    logic       t_wen   [3];
    dmem_data_t t_wdata [3];
    dmem_data_t t_rval  [3];
    logic       t_rdy   [3];

    mps_dmem_if if_a ();
    mps_dmem_if if_b ();
    mps_dmem_if if_c ();

    assign if_a.dmem_req     = t_req[0];
    assign if_a.dmem_addr    = t_addr[0];
    assign if_a.dmem_wenable = t_wen[0];
    assign if_a.dmem_wvalue  = t_wdata[0];
    assign t_rval[0]         = if_a.dmem_rvalue;
    assign t_rdy[0]          = if_a.dmem_ready;

    assign if_b.dmem_req     = t_req[1];
    assign if_b.dmem_addr    = t_addr[1];
    assign if_b.dmem_wenable = t_wen[1];
    assign if_b.dmem_wvalue  = t_wdata[1];
    assign t_rval[1]         = if_b.dmem_rvalue;
    assign t_rdy[1]          = if_b.dmem_ready;

    assign if_c.dmem_req     = t_req[2];
    assign if_c.dmem_addr    = t_addr[2];
    assign if_c.dmem_wenable = t_wen[2];
    assign if_c.dmem_wvalue  = t_wdata[2];
    assign t_rval[2]         = if_c.dmem_rvalue;
    assign t_rdy[2]          = if_c.dmem_ready;

    mps_dmem_responder #(.WAIT_STATES(2)) u_dut_a (
        .clock (clk), .reset (reset), .bus (if_a));
    mps_dmem_responder #(.WAIT_STATES(0)) u_dut_b (
        .clock (clk), .reset (reset), .bus (if_b));
    mps_dmem_responder #(.WAIT_STATES(2), .DEPTH(16)) u_dut_c (
        .clock (clk), .reset (reset), .bus (if_c));

    // Reference model: plain word arrays plus the last read result.
    dmem_data_t m_mem      [3][256];
    bit         m_known    [3][256];
    dmem_data_t m_rv       [3];
    bit         m_rv_known [3];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int wait_of(input int d);
        return (d == 1) ? 0 : 2;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 2) ? 16 : 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_rv[d]       = '0;
            m_rv_known[d] = 1'b1;
        end
    endtask

    // One transaction on responder d; entered and left at a falling edge
    // with the responder idle.
    task automatic txn(input int d, input bit w, input int a, input dmem_data_t v,
                       input bit ovr, input dmem_data_t ovr_v);
        int lat;
        bit seen;
        t_req[d]   = 1'b1;
        t_wen[d]   = w;
        t_addr[d]  = dmem_addr_t'(a);
        t_wdata[d] = v;
        @(posedge clk);
        #1;
        t_req[d]   = 1'b0;
        t_wen[d]   = 1'($urandom_range(0, 1));
        t_addr[d]  = dmem_addr_t'($urandom);
        t_wdata[d] = dmem_data_t'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            seen = t_rdy[d];
        end
        if (w) begin
            if (ovr) begin
                // counter address: storage untouched
            end else if (a < depth_of(d)) begin
                m_mem[d][a]   = v;
                m_known[d][a] = 1'b1;
            end
        end else begin
            m_rv_known[d] = 1'b1;
            if (ovr) m_rv[d] = ovr_v;
            else if (a >= depth_of(d)) m_rv[d] = '0;
            else if (m_known[d][a]) m_rv[d] = m_mem[d][a];
            else m_rv_known[d] = 1'b0;
        end
        chk($sformatf("ready_seen[%0d] a=%0d", d, a), 32'(seen), 32'd1);
        chk($sformatf("latency[%0d] a=%0d", d, a), 32'(lat), 32'(wait_of(d) + 1));
        if (m_rv_known[d])
            chk($sformatf("rvalue[%0d] a=%0d w=%0d", d, a, w), 32'(t_rval[d]), 32'(m_rv[d]));
        @(negedge clk);
        chk($sformatf("ready_one_cycle[%0d]", d), 32'(t_rdy[d]), 32'd0);
    endtask

    initial begin
        logic [15:0] mask;
        dmem_data_t  r1, r2;
        int          any_rdy;

        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            t_req[d] = 1'b0; t_wen[d] = 1'b0; t_addr[d] = '0; t_wdata[d] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_ready[%0d]", d), 32'(t_rdy[d]), 32'd0);
            chk($sformatf("reset_rvalue[%0d]", d), 32'(t_rval[d]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Write then read back with two wait states.
        txn(0, 1'b1, 5, 16'h1234, 1'b0, '0);
        txn(0, 1'b0, 5, '0, 1'b0, '0);

        // Request held high across two reads: accepts four cycles apart.
        txn(0, 1'b1, 1, dmem_data_t'($urandom), 1'b0, '0);
        txn(0, 1'b1, 2, dmem_data_t'($urandom), 1'b0, '0);
        t_req[0] = 1'b1; t_wen[0] = 1'b0; t_addr[0] = 8'd1;
        @(posedge clk);
        #1;
        t_addr[0] = 8'd2;
        mask = '0; r1 = '0; r2 = '0;
        for (int lat = 1; lat <= 8; lat++) begin
            @(negedge clk);
            if (t_rdy[0]) mask[lat] = 1'b1;
            if (lat == 3) r1 = t_rval[0];
            if (lat == 7) begin
                r2 = t_rval[0];
                t_req[0] = 1'b0;
            end
        end
        chk("held_req_ready_pattern", 32'(mask), 32'h0088);
        chk("held_req_first_read", 32'(r1), 32'(m_mem[0][1]));
        chk("held_req_second_read", 32'(r2), 32'(m_mem[0][2]));
        m_rv[0] = m_mem[0][2];

        // Zero wait states.
        txn(1, 1'b1, 3, 16'hBEEF, 1'b0, '0);
        txn(1, 1'b0, 3, '0, 1'b0, '0);

        // Reset during BUSY aborts a pending write.
        txn(0, 1'b1, 7, 16'h5555, 1'b0, '0);
        t_req[0] = 1'b1; t_wen[0] = 1'b1; t_addr[0] = 8'd7; t_wdata[0] = 16'hAAAA;
        @(posedge clk);
        #1;
        t_req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midreset_ready[%0d]", d), 32'(t_rdy[d]), 32'd0);
            chk($sformatf("midreset_rvalue[%0d]", d), 32'(t_rval[d]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        any_rdy = 0;
        repeat (5) begin
            @(negedge clk);
            if (t_rdy[0]) any_rdy++;
        end
        chk("aborted_write_no_ready", 32'(any_rdy), 32'd0);
        txn(0, 1'b0, 7, '0, 1'b0, '0);

        // Out-of-range access on the 16-word responder.
        for (int a = 0; a < 16; a++)
            txn(2, 1'b1, a, dmem_data_t'($urandom), 1'b0, '0);
        txn(2, 1'b1, 20, 16'hCAFE, 1'b0, '0);
        txn(2, 1'b0, 20, '0, 1'b0, '0);
        for (int a = 0; a < 16; a++)
            txn(2, 1'b0, a, '0, 1'b0, '0);

        // Random traffic across all three responders.
        for (int i = 0; i < 40; i++) begin
            txn($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                dmem_data_t'($urandom), 1'b0, '0);
        end

`ifdef DMEM_CYCLE_COUNTER_EN
        // Clear the counter, then read it back ten edges later.
        txn(0, 1'b1, 255, 16'h0F0F, 1'b1, '0);
        repeat (6) @(negedge clk);
        txn(0, 1'b0, 255, '0, 1'b1, 16'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mps_dmem_responder.md
MPS_DMEM_RESPONDER -- requirements
Module: mps_dmem_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, range 0..7: extra cycles between request acceptance and response.
REQ-002 SHALL have parameter DEPTH, default 2**`DMEM_ADDR_WIDTH: number of implemented data words.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port dmem_req, input, 1, level request valid from the CPU.
REQ-006 SHALL have port dmem_addr, input, `DMEM_ADDR_WIDTH, word address.
REQ-007 SHALL have port dmem_wenable, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port dmem_wvalue, input, `DMEM_DATA_WIDTH, write data.
REQ-009 SHALL have port dmem_rvalue, output, `DMEM_DATA_WIDTH, registered read data.
REQ-010 SHALL have port dmem_ready, output, 1, one-cycle completion pulse.

Function
REQ-011 SHALL implement states IDLE, BUSY and DONE.
REQ-012 In IDLE with dmem_req=1, SHALL capture addr, wenable and wvalue at the edge; go to BUSY if WAIT_STATES>0, else DONE.
REQ-013 BUSY SHALL load a wait counter with WAIT_STATES-1 on entry, decrement each cycle, and go to DONE at the edge where the counter is 0.
REQ-014 At the edge entering DONE, SHALL commit a captured write to storage, or load dmem_rvalue with the word at the captured address for a read.
REQ-015 dmem_ready SHALL be 1 only in DONE, for exactly one cycle, WAIT_STATES+1 cycles after the accepting edge.
REQ-016 DONE SHALL return to IDLE unconditionally; dmem_req is ignored in BUSY and DONE. A request held high is re-accepted on the first IDLE cycle, giving one transaction per WAIT_STATES+2 cycles.
REQ-017 Input changes during BUSY/DONE SHALL have no effect; captured copies are used.
REQ-018 dmem_rvalue SHALL hold its value until the next read completes; writes leave it unchanged.
REQ-019 Addresses >= DEPTH: writes SHALL be dropped and reads SHALL return 0, with normal ready timing.

Reset
REQ-020 Reset SHALL force IDLE, dmem_ready=0, dmem_rvalue=0, wait counter=0, and cycle counter=0 when present.
REQ-021 Reset SHALL NOT initialize storage contents.
REQ-022 Reset mid-transaction SHALL abort it: a pending write is not committed and no ready pulse is issued.

Configuration
REQ-023 With DMEM_CYCLE_COUNTER_EN defined, SHALL add a free-running `DMEM_DATA_WIDTH cycle counter at address 2**`DMEM_ADDR_WIDTH-1 that increments every clock and wraps to 0.
REQ-024 With the macro defined, a read of that address SHALL return the counter value at the DONE-entry edge, and a write SHALL clear the counter to 0 at that edge instead of writing storage; it overrides storage and the DEPTH rule.
REQ-025 Without the macro, that address SHALL behave as ordinary storage or out-of-range, and no counter logic SHALL exist.

Structure
REQ-026 SHALL take widths from config.inc.v; the WAIT_STATES/DEPTH defaults and the state encodings SHALL be added there.
REQ-027 Storage SHALL be a sub-module mps_dmem_array: DEPTH words, one synchronous write port, one registered read port.

Verification (WAIT_STATES=2, 16-bit data unless noted)
REQ-028 Write 0x1234 to addr 5, then read addr 5 -> ready 3 cycles after each accept; dmem_rvalue=0x1234 in the second ready cycle.
REQ-029 dmem_req held high for two reads of addrs 1 and 2 -> accepts exactly 4 cycles apart, two single-cycle ready pulses.
REQ-030 WAIT_STATES=0, read addr 3 holding 0xBEEF -> ready and dmem_rvalue=0xBEEF in the cycle after accept.
REQ-031 Write 0xAAAA to addr 7, reset asserted in BUSY, then read addr 7 -> no ready for the write; read returns prior contents, not 0xAAAA; outputs 0 during reset.
REQ-032 DEPTH=16: write to addr 20, then read addr 20 -> ready timing normal, dmem_rvalue=0; addr 0-15 contents unchanged.
REQ-033 DMEM_CYCLE_COUNTER_EN: write top address, then read it 10 cycles later -> returns 10; a counter at 0xFFFF wraps to 0x0000.
